// File: rtl/mac_pkg.sv
// Shared types and constants for the round-robin MAC arbiter.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mac_arb_state_e;

    // Tag pipeline depth must track the datapath depth of pipelined_mac.
    localparam int MAC_LATENCY = 2;

endpackage

// File: rtl/mac_rr_arbiter_if.sv
// Requester-side handshake and response bus of the shared MAC arbiter.
interface mac_rr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) ();

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0][WIDTH-1:0]   req_a;
    logic [NREQ-1:0][WIDTH-1:0]   req_b;
    logic [NREQ-1:0][2*WIDTH-1:0] req_c;
    logic                         rsp_valid;
    logic [IDW-1:0]               rsp_id;
    logic [2*WIDTH-1:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_c,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/pipelined_mac.sv
// Two-stage unsigned multiply-accumulate: result = a*b + c, wrapping at 2*WIDTH bits.
module pipelined_mac #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] c_q;
    logic [2*WIDTH-1:0] sum_q;

    // NOTE: datapath registers carry no reset; the arbiter's tag valid bit is
    // the only qualifier, so their post-reset contents are never observed.
    always_ff @(posedge clk) begin
        prod_q <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
        c_q    <= c;
        sum_q  <= prod_q + c_q;
    end

    assign result = sum_q;

endmodule

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined_mac among NREQ requesters, with
// an ID tag pipeline routing each result back to its issuer.
module mac_rr_arbiter
    import mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              busy,
    mac_rr_arbiter_if.slave   bus
);

    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;

    mac_arb_state_e     state;
    mac_arb_state_e     state_next;
    logic [IDW-1:0]     rr_ptr;
    tag_t [MAC_LATENCY-1:0] tags;

    logic [1:0]         inflight;
    logic               hs;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     idx;
    logic [NREQ-1:0]    grant;

    logic [WIDTH-1:0]   mac_a;
    logic [WIDTH-1:0]   mac_b;
    logic [2*WIDTH-1:0] mac_c;
    logic [2*WIDTH-1:0] mac_result;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MAC_LATENCY; i++) begin
            inflight = inflight + 2'(tags[i].v);
        end
    end

    // Walk the request vector starting at rr_ptr; first valid entry wins.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves a value held, which would infer a latch.
    always_comb begin
        hs     = 1'b0;
        winner = '0;
        idx    = '0;
        grant  = '0;
        if (state == RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(rr_ptr) + k) % NREQ);
                if (!hs && bus.req_valid[idx]) begin
                    hs     = 1'b1;
                    winner = idx;
                end
            end
        end
        if (hs) begin
            grant[winner] = 1'b1;
        end
    end

    assign bus.req_ready = grant;

    assign mac_a = hs ? bus.req_a[winner] : '0;
    assign mac_b = hs ? bus.req_b[winner] : '0;
    assign mac_c = hs ? bus.req_c[winner] : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN: begin
                if (!enable) begin
                    state_next = (inflight != 2'd0 || hs) ? DRAIN : IDLE;
                end
            end
            // Nothing issues in DRAIN, so next-cycle inflight is just the first stage.
            DRAIN: if (!tags[0].v) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            tags   <= '0;
        end else begin
            state <= state_next;
            if (hs) begin
                rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
            end
            tags[0] <= '{v: hs, id: winner};
            for (int i = 1; i < MAC_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    pipelined_mac #(.WIDTH(WIDTH)) u_mac (
        .clk    (clk),
        .a      (mac_a),
        .b      (mac_b),
        .c      (mac_c),
        .result (mac_result)
    );

    assign bus.rsp_valid = tags[MAC_LATENCY-1].v;
    assign bus.rsp_id    = tags[MAC_LATENCY-1].id;
    assign bus.rsp_data  = mac_result;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Self-checking bench: grant-order vector table, hand sequences for latency,
// wrap, drain and async reset, and a scoreboard on every returned result.
module tb_mac_rr_arbiter;
    import mac_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic busy;

    mac_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    mac_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 due;
        logic [IDW-1:0]     id;
        logic [2*WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] ready;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] mac_model(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic [2*WIDTH-1:0] c);
        logic [31:0] full;
        full = 32'(a) * 32'(b) + 32'(c);
        return full[2*WIDTH-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operands();
        for (int r = 0; r < NREQ; r++) begin
            bus.req_a[r] = WIDTH'($urandom);
            bus.req_b[r] = WIDTH'($urandom);
            bus.req_c[r] = (2*WIDTH)'($urandom);
        end
    endtask

    // Scoreboard: push on every observed handshake, pop on every response.
    logic [NREQ-1:0] mon_hs;
    exp_t            mon_e;

    always @(negedge clk) begin
        mon_hs = bus.req_valid & bus.req_ready;
        if (rst_n === 1'b1) begin
            check("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (mon_hs[i] === 1'b1) begin
                sb.push_back('{cyc + 2, IDW'(i),
                               mac_model(bus.req_a[i], bus.req_b[i], bus.req_c[i])});
            end
        end
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid id %0d data 0x%0h, expected none (cycle %0d)",
                         bus.rsp_id, bus.rsp_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                check("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
                check("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Starting from rr_ptr=3 (after the single-op test).
        vecs[0]  = '{4'b1000, 4'b1000};
        vecs[1]  = '{4'b1111, 4'b0001};
        vecs[2]  = '{4'b1111, 4'b0010};
        vecs[3]  = '{4'b1111, 4'b0100};
        vecs[4]  = '{4'b1111, 4'b1000};
        vecs[5]  = '{4'b1111, 4'b0001};
        vecs[6]  = '{4'b0010, 4'b0010};
        vecs[7]  = '{4'b1010, 4'b1000};
        vecs[8]  = '{4'b1010, 4'b0010};
        vecs[9]  = '{4'b1010, 4'b1000};
        vecs[10] = '{4'b0000, 4'b0000};
        vecs[11] = '{4'b0110, 4'b0010};
        vecs[12] = '{4'b0001, 4'b0001};
        vecs[13] = '{4'b1100, 4'b0100};
        vecs[14] = '{4'b1001, 4'b1000};

        rst_n         = 1'b0;
        enable        = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        rst_n = 1'b1;
        step();

        // Single op: request while IDLE gets no grant; granted once RUN.
        enable        = 1'b1;
        bus.req_valid = 4'b0100;
        rand_operands();
        bus.req_a[2]  = 8'd3;
        bus.req_b[2]  = 8'd5;
        bus.req_c[2]  = 16'd7;
        @(negedge clk);
        check("idle_no_grant", 32'(bus.req_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        check("single_grant", 32'(bus.req_ready), 32'b0100);
        check("run_busy", 32'(busy), 32'd1);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_id", 32'(bus.rsp_id), 32'd2);
        check("single_rsp_data", 32'(bus.rsp_data), 32'd22);
        step();

        // Round-robin order, contention and skip of invalid requesters.
        for (int i = 0; i < 15; i++) begin
            bus.req_valid = vecs[i].valid;
            rand_operands();
            @(negedge clk);
            check($sformatf("grant_vec%0d", i), 32'(bus.req_ready), 32'(vecs[i].ready));
            step();
        end

        // Wrap: 255*255 + 65535 mod 2^16.
        bus.req_valid = 4'b0100;
        bus.req_a[2]  = 8'd255;
        bus.req_b[2]  = 8'd255;
        bus.req_c[2]  = 16'hFFFF;
        @(negedge clk);
        check("wrap_grant", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = '0;
        step();
        @(negedge clk);
        check("wrap_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wrap_rsp_data", 32'(bus.rsp_data), 32'd65024);
        step();

        // Drain: handshake in the same cycle enable drops.
        bus.req_valid = 4'b0001;
        enable        = 1'b0;
        rand_operands();
        @(negedge clk);
        check("drain_n_grant", 32'(bus.req_ready), 32'b0001);
        step();
        @(negedge clk);
        check("drain_n1_ready", 32'(bus.req_ready), 32'd0);
        check("drain_n1_state", 32'(dut.state), 32'(DRAIN));
        check("drain_n1_busy", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        check("drain_n2_state", 32'(dut.state), 32'(DRAIN));
        check("drain_n2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("drain_n2_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("drain_n2_ready", 32'(bus.req_ready), 32'd0);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        check("drain_n3_state", 32'(dut.state), 32'(IDLE));
        check("drain_n3_busy", 32'(busy), 32'd0);
        step();

        // Async reset one cycle after a handshake drops the in-flight result.
        enable = 1'b1;
        step();
        bus.req_valid = 4'b0100;
        rand_operands();
        @(negedge clk);
        check("rst_pre_grant", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = '0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        bus.req_valid = 4'b1111;
        rand_operands();
        @(negedge clk);
        check("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        repeat (4) step();
        check("post_rst_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        repeat (3) step();
        check("final_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
